// File: rtl/pe_group_sched.sv
// Sequencer for one 6-MAC PE group: credit-gated operand issue, multi-pass
// accumulation of group sums, and a small result FIFO toward writeback.
module pe_group_sched #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned PE_LAT     = 3,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        layer,
    input  logic [15:0]       cfg_num_out,
    input  logic [5:0]        cfg_num_pass,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] ifmap_addr,
    output logic [5:0]        wt_addr,
    output logic              pe_en,
    output logic [3:0]        pe_layer,
    input  logic [18:0]       groupsum_in1,
    input  logic [18:0]       groupsum_in2,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data1,
    output logic [ACC_W-1:0]  res_data2,
    output logic [15:0]       res_idx
);
    localparam int unsigned LAT   = RD_LAT + PE_LAT;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    typedef struct packed {
        logic        valid;
        logic        first;
        logic        last;
        logic [15:0] idx;
    } tag_t;

    typedef struct packed {
        logic [ACC_W-1:0] d1;
        logic [ACC_W-1:0] d2;
        logic [15:0]      idx;
    } res_t;

    state_t            state, state_d;
    logic [15:0]       num_out_q, out_cnt, out_cnt_d;
    logic [5:0]        num_pass_q, pass_cnt, pass_cnt_d;
    logic [ADDR_W-1:0] addr_cnt, addr_cnt_d;
    logic              issue_c, first_c, last_c, load_cfg_c, err_c, legal_c, credit_c;
    logic              pipe_busy_c, push_c, pop_c;
    tag_t              iss_tag, exit_tag;
    tag_t              tag_pipe [LAT];
    logic [RD_LAT-1:0] en_pipe;
    logic [CNT_W-1:0]  fifo_count, fifo_count_d, pending, pending_d;
    res_t              fifo_mem [FIFO_DEPTH];
    res_t              push_data;
    logic [PTR_W-1:0]  wr_idx;
    logic [ACC_W-1:0]  acc1, acc2, ext1, ext2, sum1, sum2;

    assign legal_c  = (layer == 4'd1) || (layer == 4'd5);
    // An output may only start if every started output already has a FIFO slot.
    assign credit_c = ({1'b0, fifo_count} + {1'b0, pending}) < (CNT_W + 1)'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d    = state;
        issue_c    = 1'b0;
        load_cfg_c = 1'b0;
        err_c      = 1'b0;
        out_cnt_d  = out_cnt;
        pass_cnt_d = pass_cnt;
        addr_cnt_d = addr_cnt;
        first_c    = (pass_cnt == 6'd0);
        last_c     = (pass_cnt == num_pass_q - 6'd1);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (!legal_c) begin
                        err_c = 1'b1;
                    end else begin
                        load_cfg_c = 1'b1;
                        out_cnt_d  = '0;
                        pass_cnt_d = '0;
                        addr_cnt_d = '0;
                        state_d    = (cfg_num_out == 16'd0 || cfg_num_pass == 6'd0) ? ST_DONE : ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                issue_c = !first_c || credit_c;
                if (issue_c) begin
                    addr_cnt_d = addr_cnt + ADDR_W'(1);
                    if (last_c) begin
                        pass_cnt_d = '0;
                        out_cnt_d  = out_cnt + 16'd1;
                        if (out_cnt == num_out_q - 16'd1) state_d = ST_DRAIN;
                    end else begin
                        pass_cnt_d = pass_cnt + 6'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy_c && fifo_count == '0) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pipe_busy_c = iss_tag.valid;
        for (int unsigned i = 0; i < LAT; i++) pipe_busy_c = pipe_busy_c | tag_pipe[i].valid;
    end

    // Capture path: the tag leaving the pipeline marks the cycle the group sum is valid.
    always_comb begin
        exit_tag         = tag_pipe[LAT-1];
        ext1             = ACC_W'($signed(groupsum_in1));
        ext2             = (pe_layer == 4'd5) ? ACC_W'($signed(groupsum_in2)) : '0;
        sum1             = exit_tag.first ? ext1 : acc1 + ext1;
        sum2             = exit_tag.first ? ext2 : acc2 + ext2;
        push_c           = exit_tag.valid && exit_tag.last;
        pop_c            = res_valid && res_ready;
        push_data.d1     = sum1;
        push_data.d2     = sum2;
        push_data.idx    = exit_tag.idx;
        wr_idx           = PTR_W'(fifo_count - CNT_W'(pop_c));
        fifo_count_d     = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
        pending_d        = pending + CNT_W'(issue_c && first_c) - CNT_W'(push_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            buf_rd_en  <= 1'b0;
            ifmap_addr <= '0;
            wt_addr    <= '0;
            pe_layer   <= '0;
            num_out_q  <= '0;
            num_pass_q <= '0;
            out_cnt    <= '0;
            pass_cnt   <= '0;
            addr_cnt   <= '0;
            iss_tag    <= '0;
            en_pipe    <= '0;
            acc1       <= '0;
            acc2       <= '0;
            fifo_count <= '0;
            pending    <= '0;
            res_valid  <= 1'b0;
            for (int unsigned i = 0; i < LAT; i++)        tag_pipe[i] <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            busy      <= (state_d != ST_IDLE);
            done      <= (state_d == ST_DONE);
            cfg_err   <= err_c;
            buf_rd_en <= issue_c;
            if (issue_c) begin
                ifmap_addr <= addr_cnt;
                wt_addr    <= pass_cnt;
            end
            if (load_cfg_c) begin
                pe_layer   <= layer;
                num_out_q  <= cfg_num_out;
                num_pass_q <= cfg_num_pass;
            end
            out_cnt       <= out_cnt_d;
            pass_cnt      <= pass_cnt_d;
            addr_cnt      <= addr_cnt_d;
            iss_tag.valid <= issue_c;
            iss_tag.first <= first_c;
            iss_tag.last  <= last_c;
            iss_tag.idx   <= out_cnt;
            en_pipe[0]    <= buf_rd_en;
            for (int unsigned i = 1; i < RD_LAT; i++) en_pipe[i] <= en_pipe[i-1];
            tag_pipe[0] <= iss_tag;
            for (int unsigned i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            if (exit_tag.valid) begin
                acc1 <= sum1;
                acc2 <= sum2;
            end
            // Shift-style FIFO keeps the head in entry 0 so result ports come straight from flops.
            if (pop_c) begin
                for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) fifo_mem[i] <= fifo_mem[i+1];
            end
            if (push_c) fifo_mem[wr_idx] <= push_data;
            fifo_count <= fifo_count_d;
            pending    <= pending_d;
            res_valid  <= (fifo_count_d != '0);
        end
    end

    assign pe_en     = en_pipe[RD_LAT-1];
    assign res_data1 = fifo_mem[0].d1;
    assign res_data2 = fifo_mem[0].d2;
    assign res_idx   = fifo_mem[0].idx;

endmodule

// File: tb/tb_pe_group_sched.sv
// Bench for pe_group_sched: a PE model feeds per-issue sums and expected
// results are per-output sums of those values, truncated to 24 bits.
module tb_pe_group_sched;
    localparam int PE_LAT = 3;

    logic        clk, rst, start, res_ready;
    logic [3:0]  layer;
    logic [15:0] cfg_num_out;
    logic [5:0]  cfg_num_pass;
    logic [18:0] groupsum_in1, groupsum_in2;
    logic        busy, done, cfg_err, buf_rd_en, pe_en, res_valid;
    logic [11:0] ifmap_addr;
    logic [5:0]  wt_addr;
    logic [3:0]  pe_layer;
    logic [23:0] res_data1, res_data2;
    logic [15:0] res_idx;

    int total = 0;
    int bad   = 0;

    logic signed [18:0] stim1[$], stim2[$];
    logic [23:0] exp1[$], exp2[$];
    logic [11:0] obs_addr[$];
    logic [5:0]  obs_wt[$];
    int          obs_icyc[$];
    logic [23:0] obs_r1[$], obs_r2[$];
    logic [15:0] obs_idx[$];
    int          obs_rcyc[$];
    int done_cnt, err_cnt, busy_seen, done_cyc, first_valid_cyc, pe_en_err, issues_at_hold;
    bit timed_out;
    logic [3:0] obs_pe_layer;

    pe_group_sched dut (
        .clk(clk), .rst(rst), .start(start), .layer(layer),
        .cfg_num_out(cfg_num_out), .cfg_num_pass(cfg_num_pass),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .buf_rd_en(buf_rd_en), .ifmap_addr(ifmap_addr), .wt_addr(wt_addr),
        .pe_en(pe_en), .pe_layer(pe_layer),
        .groupsum_in1(groupsum_in1), .groupsum_in2(groupsum_in2),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data1(res_data1), .res_data2(res_data2), .res_idx(res_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each output is the plain integer sum of its passes' sums.
    task automatic calc_expect(input logic [3:0] lay, input int nout, input int npass);
        int a1, a2;
        exp1.delete();
        exp2.delete();
        while (stim1.size() < nout * npass) stim1.push_back(19'($urandom));
        while (stim2.size() < nout * npass) stim2.push_back(19'($urandom));
        for (int o = 0; o < nout; o++) begin
            a1 = 0;
            a2 = 0;
            for (int p = 0; p < npass; p++) begin
                a1 += int'(stim1[o * npass + p]);
                a2 += int'(stim2[o * npass + p]);
            end
            exp1.push_back(24'(a1));
            exp2.push_back((lay == 4'd5) ? 24'(a2) : 24'd0);
        end
    endtask

    // Runs one job: PE model (fixed latency after pe_en), writeback sink, observation logs.
    task automatic run_job(input logic [3:0] lay, input int nout, input int npass,
                           input int ready_mode, input int hold, input int restart_at,
                           input int max_cyc);
        logic [18:0] d1 [0:PE_LAT];
        logic [18:0] d2 [0:PE_LAT];
        bit          dv [0:PE_LAT];
        bit prev_rd;
        bit finished;
        prev_rd = 0;
        finished = 0;
        obs_addr.delete(); obs_wt.delete(); obs_icyc.delete();
        obs_r1.delete(); obs_r2.delete(); obs_idx.delete(); obs_rcyc.delete();
        done_cnt = 0; err_cnt = 0; busy_seen = 0; done_cyc = -1;
        first_valid_cyc = -1; pe_en_err = 0; issues_at_hold = -1;
        for (int i = 0; i <= PE_LAT; i++) begin d1[i] = '0; d2[i] = '0; dv[i] = 0; end
        @(negedge clk);
        layer = lay;
        cfg_num_out = 16'(nout);
        cfg_num_pass = 6'(npass);
        start = 1'b1;
        for (int c = 0; c < max_cyc && !finished; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == restart_at) begin
                start = 1'b1;
                layer = 4'd5;
                cfg_num_out = 16'd3;
                cfg_num_pass = 6'd2;
            end
            if (buf_rd_en) begin
                obs_addr.push_back(ifmap_addr);
                obs_wt.push_back(wt_addr);
                obs_icyc.push_back(c);
            end
            if (pe_en !== prev_rd) pe_en_err++;
            prev_rd = buf_rd_en;
            for (int i = PE_LAT; i > 0; i--) begin
                d1[i] = d1[i-1]; d2[i] = d2[i-1]; dv[i] = dv[i-1];
            end
            dv[0] = pe_en;
            if (pe_en) begin
                if (stim1.size() > 0) d1[0] = stim1.pop_front(); else d1[0] = 19'($urandom);
                if (stim2.size() > 0) d2[0] = stim2.pop_front(); else d2[0] = 19'($urandom);
            end
            groupsum_in1 = dv[PE_LAT] ? d1[PE_LAT] : 19'($urandom);
            groupsum_in2 = dv[PE_LAT] ? d2[PE_LAT] : 19'($urandom);
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
            if (cfg_err) err_cnt++;
            if (busy) busy_seen++;
            if (res_valid && first_valid_cyc < 0) first_valid_cyc = c;
            case (ready_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = 1'(c >= hold);
            endcase
            if (c == hold) issues_at_hold = obs_addr.size();
            if (res_valid && res_ready) begin
                obs_r1.push_back(res_data1);
                obs_r2.push_back(res_data2);
                obs_idx.push_back(res_idx);
                obs_rcyc.push_back(c);
            end
            if (done_cyc >= 0 && c - done_cyc >= 3) finished = 1;
        end
        timed_out = !finished;
        obs_pe_layer = pe_layer;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, cfg_err, buf_rd_en, pe_en, res_valid, ifmap_addr, wt_addr, pe_layer,
             res_data1, res_data2, res_idx} !== 92'd0) begin
            bad++;
            $display("FAIL reset_outputs busy=%b done=%b rd=%b valid=%b layer=%0d required all zero",
                     busy, done, buf_rd_en, res_valid, pe_layer);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_layer1();
        stim1.delete(); stim2.delete();
        stim1.push_back(19'(100));
        stim1.push_back(19'(-7));
        calc_expect(4'd1, 2, 1);
        run_job(4'd1, 2, 1, 0, 0, -1, 200);
        total++;
        if (timed_out || obs_r1.size() != 2 || obs_addr.size() != 2) begin
            bad++;
            $display("FAIL l1_counts results=%0d issues=%0d timeout=%0d required 2 2 0",
                     obs_r1.size(), obs_addr.size(), timed_out);
        end else begin
            total++;
            if (obs_r1[0] !== 24'd100 || obs_r2[0] !== 24'd0 || obs_idx[0] !== 16'd0) begin
                bad++;
                $display("FAIL l1_res0 got=(%0d,%0d,%0d) required (100,0,0)", $signed(obs_r1[0]), obs_r2[0], obs_idx[0]);
            end
            total++;
            if (obs_r1[1] !== 24'(-7) || obs_r2[1] !== 24'd0 || obs_idx[1] !== 16'd1) begin
                bad++;
                $display("FAIL l1_res1 got=(%0d,%0d,%0d) required (-7,0,1)", $signed(obs_r1[1]), obs_r2[1], obs_idx[1]);
            end
            total++;
            if (obs_addr[0] !== 12'd0 || obs_addr[1] !== 12'd1) begin
                bad++;
                $display("FAIL l1_addr got=%0d,%0d required 0,1", obs_addr[0], obs_addr[1]);
            end
            total++;
            if (first_valid_cyc - obs_icyc[0] != 5) begin
                bad++;
                $display("FAIL l1_latency got=%0d required 5", first_valid_cyc - obs_icyc[0]);
            end
            total++;
            if (done_cnt != 1 || done_cyc <= obs_rcyc[1]) begin
                bad++;
                $display("FAIL l1_done pulses=%0d at=%0d last_accept=%0d required 1 pulse after", done_cnt, done_cyc, obs_rcyc[1]);
            end
        end
        total++;
        if (pe_en_err != 0 || obs_pe_layer !== 4'd1) begin
            bad++;
            $display("FAIL l1_pe pe_en_mismatches=%0d pe_layer=%0d required 0 1", pe_en_err, obs_pe_layer);
        end
    endtask

    task automatic test_layer5();
        stim1.delete(); stim2.delete();
        for (int p = 1; p <= 3; p++) begin
            stim1.push_back(19'(10 * p));
            stim2.push_back(19'(-p));
        end
        calc_expect(4'd5, 1, 3);
        run_job(4'd5, 1, 3, 0, 0, -1, 200);
        total++;
        if (timed_out || obs_r1.size() != 1 || obs_wt.size() != 3) begin
            bad++;
            $display("FAIL l5_counts results=%0d issues=%0d timeout=%0d required 1 3 0",
                     obs_r1.size(), obs_wt.size(), timed_out);
        end else begin
            total++;
            if (obs_r1[0] !== 24'd60 || obs_r2[0] !== 24'(-6) || obs_idx[0] !== 16'd0) begin
                bad++;
                $display("FAIL l5_res got=(%0d,%0d,%0d) required (60,-6,0)", $signed(obs_r1[0]), $signed(obs_r2[0]), obs_idx[0]);
            end
            total++;
            if (obs_wt[0] !== 6'd0 || obs_wt[1] !== 6'd1 || obs_wt[2] !== 6'd2 || obs_icyc[2] - obs_icyc[0] != 2) begin
                bad++;
                $display("FAIL l5_wt got=%0d,%0d,%0d span=%0d required 0,1,2 span 2",
                         obs_wt[0], obs_wt[1], obs_wt[2], obs_icyc[2] - obs_icyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        stim1.delete(); stim2.delete();
        calc_expect(4'd1, 8, 1);
        run_job(4'd1, 8, 1, 2, 40, -1, 400);
        total++;
        if (issues_at_hold != 4) begin
            bad++;
            $display("FAIL bp_credit issues_while_stalled=%0d required 4", issues_at_hold);
        end
        total++;
        if (timed_out || obs_r1.size() != 8 || obs_addr.size() != 8) begin
            bad++;
            $display("FAIL bp_counts results=%0d issues=%0d timeout=%0d required 8 8 0",
                     obs_r1.size(), obs_addr.size(), timed_out);
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (obs_idx[k] !== 16'(k) || obs_r1[k] !== exp1[k] || obs_r2[k] !== 24'd0) begin
                    bad++;
                    $display("FAIL bp_res%0d got=(%0h,%0h,%0d) required (%0h,0,%0d)", k, obs_r1[k], obs_r2[k], obs_idx[k], exp1[k], k);
                end
            end
            total++;
            if (done_cnt != 1 || done_cyc <= obs_rcyc[7]) begin
                bad++;
                $display("FAIL bp_done pulses=%0d at=%0d last_accept=%0d required 1 pulse after", done_cnt, done_cyc, obs_rcyc[7]);
            end
        end
    endtask

    task automatic test_illegal_and_empty();
        stim1.delete(); stim2.delete();
        run_job(4'd3, 2, 2, 0, 0, -1, 10);
        total++;
        if (err_cnt != 1 || busy_seen != 0 || obs_addr.size() != 0 || done_cnt != 0) begin
            bad++;
            $display("FAIL illegal_layer cfg_err=%0d busy=%0d issues=%0d done=%0d required 1 0 0 0",
                     err_cnt, busy_seen, obs_addr.size(), done_cnt);
        end
        run_job(4'd1, 5, 0, 0, 0, -1, 20);
        total++;
        if (timed_out || done_cnt != 1 || obs_addr.size() != 0 || err_cnt != 0) begin
            bad++;
            $display("FAIL zero_pass done=%0d issues=%0d cfg_err=%0d timeout=%0d required 1 0 0 0",
                     done_cnt, obs_addr.size(), err_cnt, timed_out);
        end
    endtask

    task automatic test_extremes();
        stim1.delete(); stim2.delete();
        for (int p = 0; p < 32; p++) stim1.push_back(19'(-262144));
        calc_expect(4'd1, 1, 32);
        run_job(4'd1, 1, 32, 0, 0, -1, 300);
        total++;
        if (timed_out || obs_r1.size() != 1) begin
            bad++;
            $display("FAIL ext_counts results=%0d timeout=%0d required 1 0", obs_r1.size(), timed_out);
        end else begin
            total++;
            if (obs_r1[0] !== 24'(-8388608) || obs_r1[0] !== exp1[0]) begin
                bad++;
                $display("FAIL ext_sum got=%0d required -8388608", $signed(obs_r1[0]));
            end
            total++;
            if (obs_wt[31] !== 6'd31 || obs_addr[31] !== 12'd31) begin
                bad++;
                $display("FAIL ext_last_issue wt=%0d addr=%0d required 31 31", obs_wt[31], obs_addr[31]);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim1.delete(); stim2.delete();
        run_job(4'd5, 10, 3, 0, 0, -1, 8);
        rst = 1'b0;
        #1;
        total++;
        if ({busy, done, cfg_err, buf_rd_en, pe_en, res_valid, ifmap_addr, wt_addr, pe_layer,
             res_data1, res_data2, res_idx} !== 92'd0) begin
            bad++;
            $display("FAIL reset_mid busy=%b rd=%b pe_en=%b valid=%b addr=%0d required all zero",
                     busy, buf_rd_en, pe_en, res_valid, ifmap_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        stim1.delete(); stim2.delete();
        calc_expect(4'd5, 3, 2);
        run_job(4'd5, 3, 2, 0, 0, -1, 200);
        total++;
        if (timed_out || obs_r1.size() != 3 || obs_addr.size() != 6) begin
            bad++;
            $display("FAIL post_reset_counts results=%0d issues=%0d timeout=%0d required 3 6 0",
                     obs_r1.size(), obs_addr.size(), timed_out);
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_r1[k] !== exp1[k] || obs_r2[k] !== exp2[k] || obs_idx[k] !== 16'(k) || obs_addr[2*k] !== 12'(2*k)) begin
                    bad++;
                    $display("FAIL post_reset_res%0d got=(%0h,%0h,%0d) addr=%0d required (%0h,%0h,%0d) addr=%0d",
                             k, obs_r1[k], obs_r2[k], obs_idx[k], obs_addr[2*k], exp1[k], exp2[k], k, 2*k);
                end
            end
        end
    endtask

    task automatic test_restart();
        stim1.delete(); stim2.delete();
        calc_expect(4'd1, 4, 2);
        run_job(4'd1, 4, 2, 0, 0, 3, 300);
        total++;
        if (timed_out || obs_r1.size() != 4 || obs_addr.size() != 8 || obs_pe_layer !== 4'd1) begin
            bad++;
            $display("FAIL restart_counts results=%0d issues=%0d pe_layer=%0d timeout=%0d required 4 8 1 0",
                     obs_r1.size(), obs_addr.size(), obs_pe_layer, timed_out);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (obs_r1[k] !== exp1[k] || obs_r2[k] !== 24'd0 || obs_idx[k] !== 16'(k)) begin
                    bad++;
                    $display("FAIL restart_res%0d got=(%0h,%0h,%0d) required (%0h,0,%0d)",
                             k, obs_r1[k], obs_r2[k], obs_idx[k], exp1[k], k);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] lay;
        int nout, npass;
        for (int r = 0; r < 6; r++) begin
            lay = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd5;
            nout = $urandom_range(1, 6);
            npass = $urandom_range(1, 5);
            stim1.delete(); stim2.delete();
            calc_expect(lay, nout, npass);
            run_job(lay, nout, npass, 1, 0, -1, 2000);
            total++;
            if (timed_out || obs_r1.size() != nout || obs_addr.size() != nout * npass) begin
                bad++;
                $display("FAIL rnd%0d_counts results=%0d issues=%0d timeout=%0d required %0d %0d 0",
                         r, obs_r1.size(), obs_addr.size(), timed_out, nout, nout * npass);
            end else begin
                for (int k = 0; k < nout; k++) begin
                    total++;
                    if (obs_r1[k] !== exp1[k] || obs_r2[k] !== exp2[k] || obs_idx[k] !== 16'(k)) begin
                        bad++;
                        $display("FAIL rnd%0d_res%0d got=(%0h,%0h,%0d) required (%0h,%0h,%0d)",
                                 r, k, obs_r1[k], obs_r2[k], obs_idx[k], exp1[k], exp2[k], k);
                    end
                end
                for (int k = 0; k < nout * npass; k++) begin
                    total++;
                    if (obs_addr[k] !== 12'(k) || obs_wt[k] !== 6'(k % npass)) begin
                        bad++;
                        $display("FAIL rnd%0d_issue%0d addr=%0d wt=%0d required %0d %0d",
                                 r, k, obs_addr[k], obs_wt[k], k, k % npass);
                    end
                end
            end
            total++;
            if (pe_en_err != 0 || done_cnt != 1) begin
                bad++;
                $display("FAIL rnd%0d_ctrl pe_en_mismatches=%0d done=%0d required 0 1", r, pe_en_err, done_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        layer = 4'd0;
        cfg_num_out = 16'd0;
        cfg_num_pass = 6'd0;
        groupsum_in1 = '0;
        groupsum_in2 = '0;
        res_ready = 1'b0;
        test_reset();
        test_layer1();
        test_layer5();
        test_backpressure();
        test_illegal_and_empty();
        test_extremes();
        test_reset_mid();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
